// File: rtl/hci_core_rr_arbiter_pkg.sv
// Shared types and helpers for the HCI core round-robin arbiter.
// Lock states are plain sized constants so older tools and netlists can still read them.
package hci_core_rr_arbiter_pkg;

  typedef logic [0:0] hci_arb_lock_state_t;

  localparam hci_arb_lock_state_t ARB_UNLOCKED = 1'b0;
  localparam hci_arb_lock_state_t ARB_LOCKED   = 1'b1;

  localparam int unsigned HCI_BOFFS_W = 4;

  function automatic int unsigned hci_arb_id_width(input int unsigned nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

endpackage

// File: rtl/hci_core_rr_arbiter_if.sv
// HCI core port bundle: a request/grant channel plus an in-order response channel.
interface hci_core_intf
  import hci_core_rr_arbiter_pkg::*;
#(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32
);
  localparam int unsigned BW = DW / 8;

  logic                   req;
  logic                   gnt;
  logic [AW-1:0]          add;
  logic                   wen;
  logic [DW-1:0]          data;
  logic [BW-1:0]          be;
  logic [HCI_BOFFS_W-1:0] boffs;
  logic                   lrdy;
  logic [DW-1:0]          r_data;
  logic                   r_valid;
  logic                   r_opc;

  modport master (
    output req, add, wen, data, be, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc
  );

  modport slave (
    input  req, add, wen, data, be, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc
  );

endinterface

// File: rtl/hci_core_rr_arbiter_id_fifo.sv
// In-order FIFO of requester IDs; the head names the owner of the next response.
module hci_core_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] id_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok != pop_ok) count_q <= push_ok ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/hci_core_rr_arbiter.sv
// Round-robin arbiter sharing one HCI core master among NB_REQ requesters,
// with an ID FIFO that routes each in-order response back to its owner.
//
//   state        | meaning
//   ARB_UNLOCKED | winner picked combinationally from rr_ptr upward
//   ARB_LOCKED   | request stalled by memory; selection pinned to lock_id
module hci_core_rr_arbiter
  import hci_core_rr_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ          = 4,
  parameter int unsigned DW              = 64,
  parameter int unsigned AW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  hci_core_intf.slave  tcdm_slave [NB_REQ-1:0],
  hci_core_intf.master tcdm_master,
  output logic         busy_o,
  output logic         err_o
);
  localparam int unsigned IW = hci_arb_id_width(NB_REQ);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = DW / 8;

  logic [NB_REQ-1:0]      s_req, s_wen, s_lrdy, s_gnt, s_rvalid;
  logic [AW-1:0]          s_add   [NB_REQ];
  logic [DW-1:0]          s_data  [NB_REQ];
  logic [BW-1:0]          s_be    [NB_REQ];
  logic [HCI_BOFFS_W-1:0] s_boffs [NB_REQ];

  hci_arb_lock_state_t lock_q, lock_eff;
  logic [IW-1:0]       rr_ptr_q, rr_eff, lock_id_q, winner, sel, head, rr_next;
  logic [CW-1:0]       count;
  logic                full, empty, has_id, m_req, hs, pop;

  for (genvar i = 0; i < NB_REQ; i++) begin : g_slave
    assign s_req[i]   = tcdm_slave[i].req;
    assign s_wen[i]   = tcdm_slave[i].wen;
    assign s_lrdy[i]  = tcdm_slave[i].lrdy;
    assign s_add[i]   = tcdm_slave[i].add;
    assign s_data[i]  = tcdm_slave[i].data;
    assign s_be[i]    = tcdm_slave[i].be;
    assign s_boffs[i] = tcdm_slave[i].boffs;

    assign s_gnt[i]    = tcdm_master.gnt & m_req & (sel == IW'(i));
    assign s_rvalid[i] = tcdm_master.r_valid & has_id & (head == IW'(i));

    assign tcdm_slave[i].gnt     = s_gnt[i];
    assign tcdm_slave[i].r_valid = s_rvalid[i];
    assign tcdm_slave[i].r_data  = tcdm_master.r_data;
    assign tcdm_slave[i].r_opc   = tcdm_master.r_opc;
  end

  // A clear must be visible on the combinational paths in the cycle it is sampled.
  assign rr_eff   = clear_i ? '0 : rr_ptr_q;
  assign lock_eff = clear_i ? ARB_UNLOCKED : lock_q;
  assign has_id   = ~clear_i & ~empty;

  always_comb begin
    logic [IW-1:0] idx;
    idx    = '0;
    winner = rr_eff;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_eff) + k) % NB_REQ);
      if (s_req[idx]) winner = idx;
    end
  end

  assign sel     = (lock_eff == ARB_LOCKED) ? lock_id_q : winner;
  assign rr_next = (sel == IW'(NB_REQ - 1)) ? '0 : sel + 1'b1;

  // No request is issued while clearing, so no grant can be lost with the wiped IDs.
  assign m_req = s_req[sel] & ~full & ~clear_i;
  assign hs    = m_req & tcdm_master.gnt;
  assign pop   = tcdm_master.r_valid & has_id;

  assign tcdm_master.req   = m_req;
  assign tcdm_master.add   = s_add[sel];
  assign tcdm_master.wen   = s_wen[sel];
  assign tcdm_master.data  = s_data[sel];
  assign tcdm_master.be    = s_be[sel];
  assign tcdm_master.boffs = s_boffs[sel];
  assign tcdm_master.lrdy  = has_id ? s_lrdy[head] : 1'b1;

  assign err_o  = tcdm_master.r_valid & ~has_id;
  assign busy_o = (~clear_i & (count != '0)) | (|s_req);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= ARB_UNLOCKED;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else if (clear_i) begin
      lock_q    <= ARB_UNLOCKED;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (hs) rr_ptr_q <= rr_next;
      case (lock_q)
        ARB_UNLOCKED: begin
          if (m_req && !tcdm_master.gnt) begin
            lock_q    <= ARB_LOCKED;
            lock_id_q <= sel;
          end
        end
        ARB_LOCKED: begin
          if (hs) lock_q <= ARB_UNLOCKED;
        end
      endcase
    end
  end

  hci_core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (hs),
    .id_i    (sel),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_hci_core_rr_arbiter.sv
// Directed bench for hci_core_rr_arbiter: a cycle-by-cycle vector table plus a
// scoreboarded round-robin streaming sequence.
module tb_hci_core_rr_arbiter;
  import hci_core_rr_arbiter_pkg::*;

  localparam int unsigned NB  = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned MAX = 4;
  localparam int unsigned NV  = 40;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear = 1'b0;
  logic busy, err;

  logic [NB-1:0] s_req = '0, s_lrdy = '1;
  logic [NB-1:0] s_gnt, s_rv, s_ropc;
  logic [DW-1:0] s_rdata [NB];

  logic                   m_gnt = 1'b0, m_rvalid = 1'b0, m_ropc = 1'b0;
  logic [DW-1:0]          m_rdata = '0;
  logic                   m_req, m_wen, m_lrdy;
  logic [AW-1:0]          m_add;
  logic [DW-1:0]          m_data;
  logic [DW/8-1:0]        m_be;
  logic [HCI_BOFFS_W-1:0] m_boffs;

  hci_core_intf #(.DW(DW), .AW(AW)) slv_if [NB-1:0] ();
  hci_core_intf #(.DW(DW), .AW(AW)) mst_if ();

  function automatic logic [AW-1:0] exp_add(input int s);
    return 32'h0000_1000 + 32'(s) * 32'h100;
  endfunction
  function automatic logic [DW-1:0] exp_data(input int s);
    return {32'hCAFE_0000 | 32'(s), 32'h1234_5670 | 32'(s)};
  endfunction
  function automatic logic [13:0] exp_ctl(input int s);
    logic [7:0] be;
    be = 8'h01 << s;
    return {(s % 2) == 1, be, 4'(s + 5), 1'b0};
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_if
    assign slv_if[g].req   = s_req[g];
    assign slv_if[g].lrdy  = s_lrdy[g];
    assign slv_if[g].add   = exp_add(g);
    assign slv_if[g].data  = exp_data(g);
    assign slv_if[g].wen   = (g % 2) == 1;
    assign slv_if[g].be    = 8'h01 << g;
    assign slv_if[g].boffs = 4'(g + 5);
    assign s_gnt[g]   = slv_if[g].gnt;
    assign s_rv[g]    = slv_if[g].r_valid;
    assign s_rdata[g] = slv_if[g].r_data;
    assign s_ropc[g]  = slv_if[g].r_opc;
  end

  assign mst_if.gnt     = m_gnt;
  assign mst_if.r_valid = m_rvalid;
  assign mst_if.r_data  = m_rdata;
  assign mst_if.r_opc   = m_ropc;
  assign m_req   = mst_if.req;
  assign m_add   = mst_if.add;
  assign m_wen   = mst_if.wen;
  assign m_data  = mst_if.data;
  assign m_be    = mst_if.be;
  assign m_boffs = mst_if.boffs;
  assign m_lrdy  = mst_if.lrdy;

  hci_core_rr_arbiter #(
    .NB_REQ(NB), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear),
    .tcdm_slave  (slv_if),
    .tcdm_master (mst_if),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] lrdy;
    logic       e_mreq;
    logic [1:0] e_sel;
    logic [3:0] e_gnt;
    logic [3:0] e_rv;
    logic       e_lrdy;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs [NV];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   q [$];

  function automatic vec_t mk(input logic clr, input logic [3:0] req, input logic gnt,
                              input logic rv, input logic [3:0] lrdy, input logic e_mreq,
                              input logic [1:0] e_sel, input logic [3:0] e_gnt,
                              input logic [3:0] e_rv, input logic e_lrdy,
                              input logic e_busy, input logic e_err);
    vec_t v;
    v = {clr, req, gnt, rv, lrdy, e_mreq, e_sel, e_gnt, e_rv, e_lrdy, e_busy, e_err};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    // clr req gnt rv lrdy | mreq sel gnt rv lrdy busy err
    vecs[0]  = mk(0, 4'h0, 0, 0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    vecs[1]  = mk(0, 4'hF, 1, 0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 0);
    vecs[2]  = mk(0, 4'hF, 1, 1, 4'hF, 1, 1, 4'h2, 4'h1, 1, 1, 0);
    vecs[3]  = mk(0, 4'hF, 1, 1, 4'hF, 1, 2, 4'h4, 4'h2, 1, 1, 0);
    vecs[4]  = mk(0, 4'hF, 1, 1, 4'hF, 1, 3, 4'h8, 4'h4, 1, 1, 0);
    vecs[5]  = mk(0, 4'hF, 1, 1, 4'hF, 1, 0, 4'h1, 4'h8, 1, 1, 0);
    vecs[6]  = mk(0, 4'h0, 0, 1, 4'hF, 0, 1, 4'h0, 4'h1, 1, 1, 0);
    vecs[7]  = mk(0, 4'h0, 0, 1, 4'hF, 0, 1, 4'h0, 4'h0, 1, 0, 1);
    vecs[8]  = mk(0, 4'h0, 0, 0, 4'hF, 0, 1, 4'h0, 4'h0, 1, 0, 0);
    vecs[9]  = mk(0, 4'h9, 1, 0, 4'hF, 1, 3, 4'h8, 4'h0, 1, 1, 0);
    vecs[10] = mk(0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h8, 1, 1, 0);
    vecs[11] = mk(0, 4'h4, 0, 0, 4'hF, 1, 2, 4'h0, 4'h0, 1, 1, 0);
    vecs[12] = mk(0, 4'h5, 0, 0, 4'hF, 1, 2, 4'h0, 4'h0, 1, 1, 0);
    vecs[13] = mk(0, 4'h5, 0, 0, 4'hF, 1, 2, 4'h0, 4'h0, 1, 1, 0);
    vecs[14] = mk(0, 4'h5, 1, 0, 4'hF, 1, 2, 4'h4, 4'h0, 1, 1, 0);
    vecs[15] = mk(0, 4'h1, 1, 1, 4'hF, 1, 0, 4'h1, 4'h4, 1, 1, 0);
    vecs[16] = mk(0, 4'h0, 0, 1, 4'hF, 0, 1, 4'h0, 4'h1, 1, 1, 0);
    vecs[17] = mk(0, 4'h2, 1, 0, 4'hF, 1, 1, 4'h2, 4'h0, 1, 1, 0);
    vecs[18] = mk(0, 4'h0, 0, 0, 4'hD, 0, 2, 4'h0, 4'h0, 0, 1, 0);
    vecs[19] = mk(0, 4'h0, 0, 0, 4'hD, 0, 2, 4'h0, 4'h0, 0, 1, 0);
    vecs[20] = mk(0, 4'h0, 0, 1, 4'hF, 0, 2, 4'h0, 4'h2, 1, 1, 0);
    vecs[21] = mk(0, 4'h0, 0, 0, 4'hD, 0, 2, 4'h0, 4'h0, 1, 0, 0);
    vecs[22] = mk(0, 4'hF, 1, 0, 4'hF, 1, 2, 4'h4, 4'h0, 1, 1, 0);
    vecs[23] = mk(0, 4'hF, 1, 0, 4'hF, 1, 3, 4'h8, 4'h0, 1, 1, 0);
    vecs[24] = mk(0, 4'hF, 1, 0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 0);
    vecs[25] = mk(0, 4'hF, 1, 0, 4'hF, 1, 1, 4'h2, 4'h0, 1, 1, 0);
    vecs[26] = mk(0, 4'hF, 1, 0, 4'hF, 0, 2, 4'h0, 4'h0, 1, 1, 0);
    vecs[27] = mk(0, 4'hF, 1, 1, 4'hF, 0, 2, 4'h0, 4'h4, 1, 1, 0);
    vecs[28] = mk(0, 4'hF, 1, 0, 4'hF, 1, 2, 4'h4, 4'h0, 1, 1, 0);
    vecs[29] = mk(0, 4'h0, 0, 1, 4'hF, 0, 3, 4'h0, 4'h8, 1, 1, 0);
    vecs[30] = mk(1, 4'h0, 0, 0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    vecs[31] = mk(0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 1);
    vecs[32] = mk(0, 4'hA, 1, 0, 4'hF, 1, 1, 4'h2, 4'h0, 1, 1, 0);
    vecs[33] = mk(0, 4'h8, 1, 1, 4'hF, 1, 3, 4'h8, 4'h2, 1, 1, 0);
    vecs[34] = mk(0, 4'h0, 0, 1, 4'hF, 0, 0, 4'h0, 4'h8, 1, 1, 0);
    vecs[35] = mk(0, 4'h0, 0, 0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    vecs[36] = mk(0, 4'h4, 0, 0, 4'hF, 1, 2, 4'h0, 4'h0, 1, 1, 0);
    vecs[37] = mk(1, 4'h0, 0, 0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 0);
    vecs[38] = mk(0, 4'h5, 1, 0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 0);
    vecs[39] = mk(0, 4'h0, 0, 1, 4'hF, 0, 1, 4'h0, 4'h1, 1, 1, 0);

    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset m_req", m_req, 1'b0);
    chk("reset s_gnt", s_gnt, 4'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      clear    = vecs[i].clr;
      s_req    = vecs[i].req;
      s_lrdy   = vecs[i].lrdy;
      m_gnt    = vecs[i].gnt;
      m_rvalid = vecs[i].rv;
      m_rdata  = 64'hBEEF_0000_0000_0000 | 64'(i);
      m_ropc   = (i % 2) == 1;
      #1;
      chk($sformatf("v%0d m_req", i), m_req, vecs[i].e_mreq);
      chk($sformatf("v%0d sel_add", i), m_add, exp_add(int'(vecs[i].e_sel)));
      chk($sformatf("v%0d sel_data", i), m_data, exp_data(int'(vecs[i].e_sel)));
      chk($sformatf("v%0d sel_ctl", i), {m_wen, m_be, m_boffs, 1'b0},
          exp_ctl(int'(vecs[i].e_sel)));
      chk($sformatf("v%0d s_gnt", i), s_gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d s_rvalid", i), s_rv, vecs[i].e_rv);
      chk($sformatf("v%0d m_lrdy", i), m_lrdy, vecs[i].e_lrdy);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d err", i), err, vecs[i].e_err);
      if (vecs[i].rv) begin
        for (int k = 0; k < NB; k++)
          chk($sformatf("v%0d r_data s%0d", i, k), {s_ropc[k], s_rdata[k]},
              {(i % 2) == 1, 64'hBEEF_0000_0000_0000 | 64'(i)});
      end
    end

    // Streaming: slaves 0 and 2 alternate; every response must reach the granted owner.
    begin
      int exp_next, ngrant, cyc;
      exp_next = 2;
      ngrant   = 0;
      cyc      = 0;
      q.delete();
      while (ngrant < 6 && cyc < 40) begin
        @(negedge clk);
        clear    = 1'b0;
        s_req    = 4'b0101;
        s_lrdy   = 4'hF;
        m_gnt    = 1'b1;
        m_rvalid = (q.size() > 0);
        m_rdata  = 64'h5EED_0000 + 64'(cyc);
        #1;
        if (m_rvalid) begin
          chk("stream r_valid", s_rv, 4'(1 << q[0]));
          void'(q.pop_front());
        end
        if (s_gnt != 4'h0) begin
          chk("stream grant", s_gnt, 4'(1 << exp_next));
          q.push_back(exp_next);
          exp_next = (exp_next == 2) ? 0 : 2;
          ngrant++;
        end
        cyc++;
      end
      chk("stream grant budget", 32'(ngrant), 32'd6);
      cyc = 0;
      while (q.size() > 0 && cyc < 8) begin
        @(negedge clk);
        s_req    = 4'h0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b1;
        #1;
        chk("drain r_valid", s_rv, 4'(1 << q[0]));
        void'(q.pop_front());
        cyc++;
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      chk("drain idle busy", busy, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
